flash_sample_sequencer: RTL and testbench
=========================================

# flash_sample_sequencer

Sequences word reads from the flash read controller and turns them into a 16-bit audio sample stream for the music player. It sits between the flash read controller's request port (address, read strobe, busy, data, error) and the audio output path. It steps the word address forward or backward with wrap-around and prefetches one word. It emits one sample per audio-rate tick, two samples per 32-bit flash word.

## Interface
- `START_ADDR`, 23'h000000: first word address of the song.
- `END_ADDR`, 23'h07FFFF: last word address of the song, inclusive. Must be ≥ `START_ADDR`.
- `clk`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  reset; asynchronous, active-low.
- `sample_tick`  in  1  one-cycle pulse at the audio sample rate.
- `play`  in  1  1 = consume ticks; 0 = paused.
- `dir`  in  1  0 = forward, 1 = backward.
- `restart`  in  1  one-cycle pulse; return to the song start for the current `dir`.
- `rd_addr`  out  23  word address to the flash controller (its `MEM_ADDR`).
- `rd_req`  out  1  one-cycle read strobe to the flash controller.
- `rd_busy`  in  1  flash controller busy.
- `rd_data`  in  32  flash controller read data.
- `rd_error`  in  1  flash controller error, sampled at completion.
- `sample_out`  out  16  current audio sample, held between updates.
- `sample_valid`  out  1  one-cycle pulse when `sample_out` updates.
- `underrun`  out  1  sticky; a tick arrived with no word buffered.
- `err`  out  1  sticky; a fetch completed with `rd_error=1`, or a watchdog abort occurred.

## Operation
- Reset values: `rd_addr`=`START_ADDR`, `rd_req`=0, `sample_out`=0, `sample_valid`=0, `underrun`=0, `err`=0, state IDLE, buffer empty.
- States and transitions:
  - IDLE → REQ when the buffer is empty and `rd_busy`=0.
  - REQ drives `rd_req`=1 for exactly one cycle, then → WAIT_BUSY.
  - WAIT_BUSY → WAIT_DONE when `rd_busy`=1.
  - WAIT_DONE: on the first cycle with `rd_busy`=0, captures `rd_data` into the word buffer and → READY.
    - If `rd_error`=1 in that cycle, the buffer is loaded with 0 and `err` is set.
  - READY → IDLE once both halves are consumed. On that exit `rd_addr` steps to the next address.
- Prefetch runs after reset regardless of `play`.
- Half order is latched at capture:
  - `dir`=0: `[15:0]` first, then `[31:16]`.
  - `dir`=1: `[31:16]` first, then `[15:0]`.
- Sample consumption: in READY with `play`=1, each `sample_tick` loads the next half into `sample_out`.
- Address step uses the `dir` value in the cycle of the step:
  - Forward: `END_ADDR` wraps to `START_ADDR`.
  - Backward: `START_ADDR` wraps to `END_ADDR`.
- Underrun: a tick with `play`=1 outside READY sets `underrun`. `sample_out` holds its value and `sample_valid` stays 0.
- Pause: with `play`=0, ticks are ignored. An in-flight fetch still completes; the buffer and outputs hold.
- Restart:
  - In IDLE or READY: the buffer is discarded, `rd_addr` is set to `START_ADDR` (`dir`=0) or `END_ADDR` (`dir`=1), and the state goes to IDLE.
  - In REQ, WAIT_BUSY or WAIT_DONE: restart is latched and applied when the fetch completes. The fetched word is discarded and `err` is not updated by it.
- Simultaneous events: restart and tick in the same cycle → restart wins and no sample is emitted.
- `rd_req` is never asserted while `rd_busy`=1.

## Timing
- `sample_valid` pulses and `sample_out` updates in the cycle after the `sample_tick` cycle.
- Fetch:
  - `rd_req` is asserted the cycle after IDLE sees empty buffer and `rd_busy`=0.
  - The buffer loads in the cycle after `rd_busy` is seen falling.
  - Minimum prefetch-to-READY is 4 cycles plus flash controller latency.
- `rd_addr` is stable from REQ until the fetch completes.
- Asserting `RST` mid-fetch returns all outputs to their reset values immediately. The flash controller is assumed reset by the same `RST`.

## Configuration
- `FLASH_SEQ_TIMEOUT_EN` defined: a watchdog is compiled in.
  - WAIT_BUSY aborts if `rd_busy` is not seen high within 16 cycles.
  - WAIT_DONE aborts after 256 cycles with `rd_busy` high.
  - Abort sets `err`, loads a zero word and → READY.
- `FLASH_SEQ_TIMEOUT_EN` undefined: the sequencer waits indefinitely in WAIT_BUSY and WAIT_DONE; `err` is set only by `rd_error`.

## Test plan
- Reset, then `START_ADDR`=0xA, flash model returns `{9'b0, addr}`, `play`=1, `dir`=0, two ticks → `sample_out` 0x000A then 0x0000; next fetch uses `rd_addr`=0xB.
- `dir`=1 with `START_ADDR`=0, `END_ADDR`=3, then restart → fetch at 0x3, samples 0x0000 then 0x0003; next word address 0x2; after word 0x0 the address wraps to 0x3.
- Forward with `END_ADDR`=3, consume word 0x3 → next `rd_addr`=`START_ADDR`=0x0.
- Hold `rd_busy`=1 for 8 cycles around `rd_req` and tick during the fetch → `underrun`=1 and `sample_out` unchanged; after the fetch, data for 0xA is correct and `rd_req` is never high while `rd_busy`=1.
- `restart` pulse during WAIT_DONE at `rd_addr`=0x5 (`dir`=0) → word 0x5 discarded; the next `rd_req` is at `START_ADDR`.
- `rd_error`=1 at completion → `err`=1 and both samples 0x0000. With `FLASH_SEQ_TIMEOUT_EN` defined, `rd_busy` stuck at 0 after `rd_req` → abort at 16 cycles and `err`=1.

Source files
------------

// File: rtl/flash_sample_sequencer.sv
// flash_sample_sequencer
// Fetches 32-bit words from the flash read controller, keeping one word
// buffered ahead of the audio path, and plays each word out as two 16-bit
// samples, one per sample_tick. The word address walks forward or backward
// through [START_ADDR, END_ADDR] with wrap-around.
// Optional build macro: FLASH_SEQ_TIMEOUT_EN adds a watchdog on both flash
// wait states; without it the sequencer waits on the controller indefinitely.
module flash_sample_sequencer #(
  parameter logic [22:0] START_ADDR = 23'h000000,
  parameter logic [22:0] END_ADDR   = 23'h07FFFF
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        sample_tick,
  input  logic        play,
  input  logic        dir,
  input  logic        restart,
  output logic [22:0] rd_addr,
  output logic        rd_req,
  input  logic        rd_busy,
  input  logic [31:0] rd_data,
  input  logic        rd_error,
  output logic [15:0] sample_out,
  output logic        sample_valid,
  output logic        underrun,
  output logic        err
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_REQ       = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_READY     = 3'd4
  } state_e;

  // Next word address in the playback direction, wrapping at the song ends.
  function automatic logic [22:0] step_addr(input logic [22:0] addr, input logic back);
    logic [22:0] nxt;
    if (back) begin
      if (addr == START_ADDR) nxt = END_ADDR;
      else                    nxt = addr - 23'd1;
    end else begin
      if (addr == END_ADDR)   nxt = START_ADDR;
      else                    nxt = addr + 23'd1;
    end
    return nxt;
  endfunction

  // First word of the song as seen from the given playback direction.
  function automatic logic [22:0] song_start(input logic back);
    return back ? END_ADDR : START_ADDR;
  endfunction

  // Select one 16-bit half of a buffered word.
  function automatic logic [15:0] pick_half(input logic [31:0] word, input logic hi);
    return hi ? word[31:16] : word[15:0];
  endfunction

  state_e      state_q, state_d;
  logic [22:0] rd_addr_q, rd_addr_d;
  logic        rd_req_q, rd_req_d;
  logic [31:0] buf_q, buf_d;
  logic        order_q, order_d;      // 1: high half plays first
  logic        half_q, half_d;        // 0: first half is next, 1: second half is next
  logic [15:0] sample_out_q, sample_out_d;
  logic        sample_valid_q, sample_valid_d;
  logic        underrun_q, underrun_d;
  logic        err_q, err_d;
  logic        rst_pend_q, rst_pend_d; // restart seen while a fetch is in flight

  logic tick_play_s;
  logic in_fetch_s;
  logic fetch_done_s;
  logic abort_s;
  logic complete_s;
  logic restart_pend_s;
  logic restart_now_s;
  logic consume_s;

  assign tick_play_s    = sample_tick & play;
  assign in_fetch_s     = (state_q == ST_REQ) | (state_q == ST_WAIT_BUSY) | (state_q == ST_WAIT_DONE);
  assign fetch_done_s   = (state_q == ST_WAIT_DONE) & ~rd_busy;
  assign complete_s     = fetch_done_s | abort_s;
  assign restart_pend_s = rst_pend_q | restart;
  assign restart_now_s  = restart & ((state_q == ST_IDLE) | (state_q == ST_READY));
  // A restart in the same cycle as a tick suppresses the sample.
  assign consume_s      = (state_q == ST_READY) & tick_play_s & ~restart;

`ifdef FLASH_SEQ_TIMEOUT_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;

  // Count cycles spent waiting on the controller in the current wait state.
  always_comb begin
    wd_cnt_d = 8'd0;
    case (state_q)
      ST_WAIT_BUSY: begin
        if (rd_busy) wd_cnt_d = 8'd0;
        else         wd_cnt_d = wd_cnt_q + 8'd1;
      end
      ST_WAIT_DONE: begin
        if (rd_busy) wd_cnt_d = wd_cnt_q + 8'd1;
        else         wd_cnt_d = 8'd0;
      end
      default: wd_cnt_d = 8'd0;
    endcase
  end

  // Watchdog counter register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) wd_cnt_q <= 8'd0;
    else      wd_cnt_q <= wd_cnt_d;
  end

  // Busy never rose within 16 cycles, or busy stayed high for 256 cycles.
  assign abort_s = ((state_q == ST_WAIT_BUSY) & ~rd_busy & (wd_cnt_q == 8'd15)) |
                   ((state_q == ST_WAIT_DONE) &  rd_busy & (wd_cnt_q == 8'd255));
`else
  assign abort_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic for the fetch/playback sequence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (restart)       state_d = ST_IDLE;
        else if (!rd_busy) state_d = ST_REQ;
        else               state_d = ST_IDLE;
      end
      ST_REQ: state_d = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (abort_s)      state_d = restart_pend_s ? ST_IDLE : ST_READY;
        else if (rd_busy) state_d = ST_WAIT_DONE;
        else              state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_DONE: begin
        if (complete_s) state_d = restart_pend_s ? ST_IDLE : ST_READY;
        else            state_d = ST_WAIT_DONE;
      end
      ST_READY: begin
        if (restart)                state_d = ST_IDLE;
        else if (consume_s & half_q) state_d = ST_IDLE;
        else                        state_d = ST_READY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values: address, word buffer, samples, flags.
  always_comb begin
    rd_addr_d      = rd_addr_q;
    buf_d          = buf_q;
    order_d        = order_q;
    half_d         = half_q;
    sample_out_d   = sample_out_q;
    sample_valid_d = 1'b0;
    err_d          = err_q;
    rst_pend_d     = rst_pend_q;
    rd_req_d       = (state_d == ST_REQ);

    if (tick_play_s && (state_q != ST_READY)) underrun_d = 1'b1;
    else                                      underrun_d = underrun_q;

    if (restart_now_s) begin
      rd_addr_d  = song_start(dir);
      buf_d      = 32'd0;
      half_d     = 1'b0;
      rst_pend_d = 1'b0;
    end else if (in_fetch_s) begin
      if (complete_s) begin
        rst_pend_d = 1'b0;
        half_d     = 1'b0;
        order_d    = dir;
        if (restart_pend_s) begin
          // Deferred restart: the fetched word is dropped and its error ignored.
          rd_addr_d = song_start(dir);
          buf_d     = 32'd0;
          err_d     = err_q | abort_s;
        end else begin
          buf_d = (fetch_done_s && !rd_error) ? rd_data : 32'd0;
          err_d = err_q | abort_s | (fetch_done_s & rd_error);
        end
      end else begin
        rst_pend_d = restart_pend_s;
      end
    end else if (consume_s) begin
      sample_out_d   = pick_half(buf_q, order_q ^ half_q);
      sample_valid_d = 1'b1;
      if (half_q) begin
        half_d    = 1'b0;
        buf_d     = 32'd0;
        rd_addr_d = step_addr(rd_addr_q, dir);
      end else begin
        half_d = 1'b1;
      end
    end else begin
      rst_pend_d = rst_pend_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      rd_addr_q      <= START_ADDR;
      rd_req_q       <= 1'b0;
      buf_q          <= 32'd0;
      order_q        <= 1'b0;
      half_q         <= 1'b0;
      sample_out_q   <= 16'd0;
      sample_valid_q <= 1'b0;
      underrun_q     <= 1'b0;
      err_q          <= 1'b0;
      rst_pend_q     <= 1'b0;
    end else begin
      rd_addr_q      <= rd_addr_d;
      rd_req_q       <= rd_req_d;
      buf_q          <= buf_d;
      order_q        <= order_d;
      half_q         <= half_d;
      sample_out_q   <= sample_out_d;
      sample_valid_q <= sample_valid_d;
      underrun_q     <= underrun_d;
      err_q          <= err_d;
      rst_pend_q     <= rst_pend_d;
    end
  end

  assign rd_addr      = rd_addr_q;
  assign rd_req       = rd_req_q;
  assign sample_out   = sample_out_q;
  assign sample_valid = sample_valid_q;
  assign underrun     = underrun_q;
  assign err          = err_q;

endmodule

// File: tb/tb_flash_sample_sequencer.sv
// Directed bench for flash_sample_sequencer. Two instances: A uses
// START_ADDR=0xA (default END_ADDR), B uses START_ADDR=0, END_ADDR=3.
// A behavioural flash controller returns {9'b0, addr} for every word.
module tb_flash_sample_sequencer;

  logic        clk;
  logic        RST;
  logic        sample_tick [2];
  logic        play        [2];
  logic        dir         [2];
  logic        restart     [2];
  logic [22:0] rd_addr     [2];
  logic        rd_req      [2];
  logic        rd_busy     [2];
  logic [31:0] rd_data     [2];
  logic        rd_error    [2];
  logic [15:0] sample_out  [2];
  logic        sample_valid[2];
  logic        underrun    [2];
  logic        err         [2];

  // Flash model controls and observations
  int          lat           [2];
  int          cnt           [2];
  logic        inj_err       [2];
  logic        stuck         [2];
  logic [22:0] lat_addr      [2];
  logic [22:0] last_req_addr [2];
  int          req_cnt       [2];
  int          done_cnt      [2];
  logic        req_while_busy[2];

  int errors;
  int checks;

  flash_sample_sequencer #(.START_ADDR(23'h00000A), .END_ADDR(23'h07FFFF)) u_dut_a (
    .clk(clk), .RST(RST), .sample_tick(sample_tick[0]), .play(play[0]), .dir(dir[0]),
    .restart(restart[0]), .rd_addr(rd_addr[0]), .rd_req(rd_req[0]), .rd_busy(rd_busy[0]),
    .rd_data(rd_data[0]), .rd_error(rd_error[0]), .sample_out(sample_out[0]),
    .sample_valid(sample_valid[0]), .underrun(underrun[0]), .err(err[0])
  );

  flash_sample_sequencer #(.START_ADDR(23'h000000), .END_ADDR(23'h000003)) u_dut_b (
    .clk(clk), .RST(RST), .sample_tick(sample_tick[1]), .play(play[1]), .dir(dir[1]),
    .restart(restart[1]), .rd_addr(rd_addr[1]), .rd_req(rd_req[1]), .rd_busy(rd_busy[1]),
    .rd_data(rd_data[1]), .rd_error(rd_error[1]), .sample_out(sample_out[1]),
    .sample_valid(sample_valid[1]), .underrun(underrun[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flash controller model: busy for lat cycles after a request, then data.
  initial begin
    for (int i = 0; i < 2; i++) begin
      rd_busy[i] = 1'b0; rd_data[i] = 32'd0; rd_error[i] = 1'b0; cnt[i] = 0;
      req_cnt[i] = 0; done_cnt[i] = 0; req_while_busy[i] = 1'b0;
      lat_addr[i] = 23'd0; last_req_addr[i] = 23'd0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!RST) begin
          rd_busy[i] = 1'b0;
          cnt[i] = 0;
        end else begin
          if (rd_req[i] && rd_busy[i]) req_while_busy[i] = 1'b1;
          if (rd_req[i]) begin
            req_cnt[i]++;
            last_req_addr[i] = rd_addr[i];
          end
          if (rd_busy[i]) begin
            cnt[i]--;
            if (cnt[i] == 0) begin
              rd_busy[i]  = 1'b0;
              rd_data[i]  = {9'd0, lat_addr[i]};
              rd_error[i] = inj_err[i];
              done_cnt[i]++;
            end
          end else if (rd_req[i] && !stuck[i]) begin
            rd_busy[i]  = 1'b1;
            rd_error[i] = 1'b0;
            cnt[i]      = lat[i];
            lat_addr[i] = rd_addr[i];
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One tick pulse, then check the sample outputs one edge later.
  task automatic tick_chk(input int i, input logic exp_v, input logic [15:0] exp_o, input string tag);
    @(posedge clk); #1 sample_tick[i] = 1'b1;
    @(posedge clk); #1 sample_tick[i] = 1'b0;
    chk({tag, "_valid"}, {31'd0, sample_valid[i]}, {31'd0, exp_v});
    chk({tag, "_out"}, {16'd0, sample_out[i]}, {16'd0, exp_o});
  endtask

  task automatic pulse_restart(input int i, input logic with_tick);
    @(posedge clk); #1 restart[i] = 1'b1; sample_tick[i] = with_tick;
    @(posedge clk); #1 restart[i] = 1'b0; sample_tick[i] = 1'b0;
  endtask

  // Wait (bounded) until the model has completed n fetches, then let READY settle.
  task automatic wait_done(input int i, input int n, input string tag);
    int c;
    c = 0;
    while (done_cnt[i] < n && c < 400) begin
      @(posedge clk);
      c++;
    end
    chk({tag, "_fetch_bound"}, {31'd0, (done_cnt[i] >= n)}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic consume(input int i, input int n, input logic [15:0] s0, input logic [15:0] s1,
                         input logic [22:0] nxt, input string tag);
    wait_done(i, n, tag);
    tick_chk(i, 1'b1, s0, {tag, "_s0"});
    tick_chk(i, 1'b1, s1, {tag, "_s1"});
    chk({tag, "_next_addr"}, {9'd0, rd_addr[i]}, {9'd0, nxt});
  endtask

  initial begin
    errors = 0;
    checks = 0;
    RST = 1'b0;
    for (int i = 0; i < 2; i++) begin
      sample_tick[i] = 1'b0; play[i] = 1'b1; dir[i] = 1'b0; restart[i] = 1'b0;
      lat[i] = 3; inj_err[i] = 1'b0; stuck[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_req%0d", i), {31'd0, rd_req[i]}, 32'd0);
      chk($sformatf("rst_out%0d", i), {16'd0, sample_out[i]}, 32'd0);
      chk($sformatf("rst_valid%0d", i), {31'd0, sample_valid[i]}, 32'd0);
      chk($sformatf("rst_underrun%0d", i), {31'd0, underrun[i]}, 32'd0);
      chk($sformatf("rst_err%0d", i), {31'd0, err[i]}, 32'd0);
    end
    chk("rst_addr_a", {9'd0, rd_addr[0]}, 32'h0000000A);
    chk("rst_addr_b", {9'd0, rd_addr[1]}, 32'h00000000);

    @(negedge clk);
    RST = 1'b1;

    // A: forward playback of word 0xA, then next fetch at 0xB
    wait_done(0, 1, "a_w0");
    chk("a_w0_req_addr", {9'd0, last_req_addr[0]}, 32'h0000000A);
    tick_chk(0, 1'b1, 16'h000A, "a_w0_lo");
    tick_chk(0, 1'b1, 16'h0000, "a_w0_hi");
    chk("a_step", {9'd0, rd_addr[0]}, 32'h0000000B);
    wait_done(0, 2, "a_w1");
    chk("a_w1_req_addr", {9'd0, last_req_addr[0]}, 32'h0000000B);
    tick_chk(0, 1'b1, 16'h000B, "a_w1_lo");

    // A: restart together with a tick, then a slow fetch with a tick inside it
    lat[0] = 8;
    chk("a_no_underrun", {31'd0, underrun[0]}, 32'd0);
    pulse_restart(0, 1'b1);
    chk("a_rst_tick_valid", {31'd0, sample_valid[0]}, 32'd0);
    chk("a_rst_tick_out", {16'd0, sample_out[0]}, 32'h0000000B);
    chk("a_rst_addr", {9'd0, rd_addr[0]}, 32'h0000000A);
    @(posedge clk); #1;
    tick_chk(0, 1'b0, 16'h000B, "a_underrun_tick");
    chk("a_underrun", {31'd0, underrun[0]}, 32'd1);
    consume(0, 3, 16'h000A, 16'h0000, 23'h00000B, "a_slow");

    // A: restart during WAIT_DONE of word 0xB; its error must be ignored
    inj_err[0] = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    pulse_restart(0, 1'b0);
    chk("a_addr_stable", {9'd0, rd_addr[0]}, 32'h0000000B);
    wait_done(0, 4, "a_disc");
    inj_err[0] = 1'b0;
    chk("a_disc_err", {31'd0, err[0]}, 32'd0);
    chk("a_disc_addr", {9'd0, rd_addr[0]}, 32'h0000000A);
    wait_done(0, 5, "a_refetch");
    chk("a_refetch_req_addr", {9'd0, last_req_addr[0]}, 32'h0000000A);
    tick_chk(0, 1'b1, 16'h000A, "a_refetch_lo");

    // A: read error on word 0xB zeroes the word and sets err
    inj_err[0] = 1'b1;
    tick_chk(0, 1'b1, 16'h0000, "a_refetch_hi");
    wait_done(0, 6, "a_errw");
    inj_err[0] = 1'b0;
    chk("a_errw_req_addr", {9'd0, last_req_addr[0]}, 32'h0000000B);
    chk("a_err_set", {31'd0, err[0]}, 32'd1);
    tick_chk(0, 1'b1, 16'h0000, "a_errw_lo");
    tick_chk(0, 1'b1, 16'h0000, "a_errw_hi");
    chk("a_errw_next", {9'd0, rd_addr[0]}, 32'h0000000C);

    // B: backward from END_ADDR=3 with wrap 0 -> 3
    wait_done(1, 1, "b_w0");
    dir[1] = 1'b1;
    pulse_restart(1, 1'b0);
    chk("b_rst_addr", {9'd0, rd_addr[1]}, 32'h00000003);
    wait_done(1, 2, "b_w3");
    chk("b_w3_req_addr", {9'd0, last_req_addr[1]}, 32'h00000003);
    tick_chk(1, 1'b1, 16'h0000, "b_w3_hi");
    tick_chk(1, 1'b1, 16'h0003, "b_w3_lo");
    chk("b_w3_next", {9'd0, rd_addr[1]}, 32'h00000002);
    consume(1, 3, 16'h0000, 16'h0002, 23'h000001, "b_w2");
    consume(1, 4, 16'h0000, 16'h0001, 23'h000000, "b_w1");
    consume(1, 5, 16'h0000, 16'h0000, 23'h000003, "b_w0wrap");
    dir[1] = 1'b0;

    // B: forward through END_ADDR wraps to START_ADDR
    consume(1, 6, 16'h0003, 16'h0000, 23'h000000, "b_fwd3");

    // B: paused ticks are ignored
    wait_done(1, 7, "b_w0f");
    play[1] = 1'b0;
    tick_chk(1, 1'b0, 16'h0000, "b_pause");
    chk("b_pause_underrun", {31'd0, underrun[1]}, 32'd0);
    play[1] = 1'b1;
    tick_chk(1, 1'b1, 16'h0000, "b_w0f_lo");

`ifdef FLASH_SEQ_TIMEOUT_EN
    // B: controller never goes busy; watchdog aborts after 16 cycles
    stuck[1] = 1'b1;
    tick_chk(1, 1'b1, 16'h0000, "b_w0f_hi");
    chk("b_wd_addr", {9'd0, rd_addr[1]}, 32'h00000001);
    repeat (10) @(posedge clk);
    #1;
    chk("b_wd_early", {31'd0, err[1]}, 32'd0);
    repeat (14) @(posedge clk);
    #1;
    chk("b_wd_err", {31'd0, err[1]}, 32'd1);
    stuck[1] = 1'b0;
    tick_chk(1, 1'b1, 16'h0000, "b_wd_word");
`endif

    chk("a_req_while_busy", {31'd0, req_while_busy[0]}, 32'd0);
    chk("b_req_while_busy", {31'd0, req_while_busy[1]}, 32'd0);
    chk("b_err_clear", {31'd0, err[1]},
`ifdef FLASH_SEQ_TIMEOUT_EN
        32'd1);
`else
        32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
